// File: rtl/spi_master_ctrl_if.sv
// Host handshake and SPI pin bundle for the SPI master sequencer.
// master: host/bench side, slave: the sequencer itself.
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic              cs_n;

  modport master (
    output start, tx_data, miso,
    input  busy, done, rx_data,
    input  sclk, mosi, cs_n
  );

  modport slave (
    input  start, tx_data, miso,
    output busy, done, rx_data,
    output sclk, mosi, cs_n
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// SPI mode 0 master sequencer, MSB first, single slave.
// Every state lasts CLK_DIV cycles; all outputs are registered.
module spi_master_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              reset,
  spi_master_ctrl_if.slave  bus
);
  localparam int DV_W = $clog2(CLK_DIV) + 1;
  localparam int BC_W = $clog2(DATA_W) + 1;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HI,
    LO,
    HOLD
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [DV_W-1:0]   div_cnt;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              tick;
  logic              hi_entry;

  assign tick     = (div_cnt == DV_W'(CLK_DIV - 1));
  assign hi_entry = (state_n == HI) && (state != HI);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (bus.start) state_n = SETUP;
      SETUP: if (tick) state_n = HI;
      HI:    if (tick) state_n = LO;
      // bit_cnt was bumped on LO entry
      LO: if (tick) begin
        if (bit_cnt < BC_W'(DATA_W)) state_n = HI;
        else                         state_n = HOLD;
      end
      HOLD:  if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt     <= '0;
      bit_cnt     <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rx_data <= '0;
      bus.sclk    <= 1'b0;
      bus.mosi    <= 1'b0;
      bus.cs_n    <= 1'b1;
    end else begin
      bus.done <= 1'b0;
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;

      if (state == IDLE && bus.start) begin
        tx_sr    <= bus.tx_data;
        bus.mosi <= bus.tx_data[DATA_W-1];
        bus.cs_n <= 1'b0;
        bus.busy <= 1'b1;
        bit_cnt  <= '0;
      end

      if (hi_entry) begin
        bus.sclk <= 1'b1;
        rx_sr    <= {rx_sr[DATA_W-2:0], bus.miso};
      end

      if (state == HI && tick) begin
        bus.sclk <= 1'b0;
        bit_cnt  <= bit_cnt + 1'b1;
        if (bit_cnt < BC_W'(DATA_W - 1)) begin
          tx_sr    <= tx_sr << 1;
          bus.mosi <= tx_sr[DATA_W-2];
        end else begin
          bus.mosi <= 1'b0;
        end
      end

      if (state == HOLD && tick) begin
        bus.cs_n    <= 1'b1;
        bus.busy    <= 1'b0;
        bus.done    <= 1'b1;
        bus.rx_data <= rx_sr;
      end
    end
  end
endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: 8-bit/div-4 and 16-bit/div-1
// instances, loopback and tied miso.
module tb_spi_master_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   mode = 0;

  always #5 clk = ~clk;

  spi_master_ctrl_if #(.DATA_W(8))  b1 ();
  spi_master_ctrl_if #(.DATA_W(16)) b2 ();

  // 0: loopback, 1: tied high, 2: tied low
  assign b1.miso = (mode == 0) ? b1.mosi :
                   (mode == 1) ? 1'b1 : 1'b0;
  assign b2.miso = b2.mosi;

  spi_master_ctrl #(.DATA_W(8), .CLK_DIV(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  spi_master_ctrl #(.DATA_W(16), .CLK_DIV(1)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (b2.slave)
  );

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic run_xfer(
    input  logic [7:0] tx,
    input  int         restart_at,
    output int         done_at,
    output int         ndone,
    output int         rises,
    output logic [7:0] mbits,
    output int         cslow,
    output int         mosi_hi
  );
    logic prev;
    done_at = -1;
    ndone   = 0;
    rises   = 0;
    mbits   = '0;
    cslow   = 0;
    mosi_hi = 0;
    b1.tx_data = tx;
    b1.start   = 1'b1;
    tick1();
    b1.start = 1'b0;
    prev = b1.sclk;
    if (!b1.cs_n) cslow++;
    if (b1.mosi) mosi_hi++;
    for (int c = 1; c <= 100; c++) begin
      tick1();
      if (b1.sclk && !prev) begin
        rises++;
        mbits = {mbits[6:0], b1.mosi};
      end
      prev = b1.sclk;
      if (b1.mosi) mosi_hi++;
      if (!b1.cs_n) cslow++;
      if (b1.done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
      if (c == restart_at) begin
        b1.tx_data = 8'h3C;
        b1.start   = 1'b1;
      end else begin
        b1.start = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick1();
    tick1();
    n_chk++;
    if ({b1.busy, b1.done, b1.sclk, b1.mosi, b1.cs_n} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_pins1 got %b want 00001",
               {b1.busy, b1.done, b1.sclk, b1.mosi, b1.cs_n});
    end
    n_chk++;
    if (b1.rx_data !== 8'h00 || b2.rx_data !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_rx got %h/%h want 0", b1.rx_data, b2.rx_data);
    end
    n_chk++;
    if ({b2.busy, b2.done, b2.sclk, b2.mosi, b2.cs_n} !== 5'b00001) begin
      n_fail++;
      $display("FAIL reset_pins2 got %b want 00001",
               {b2.busy, b2.done, b2.sclk, b2.mosi, b2.cs_n});
    end
    reset = 1'b0;
    tick1();
  endtask

  task automatic test_loopback();
    int d, n, r, cl, mh;
    logic [7:0] mb;
    mode = 0;
    run_xfer(8'hA5, -1, d, n, r, mb, cl, mh);
    n_chk++;
    if (d !== 72) begin
      n_fail++;
      $display("FAIL lb_done_at got %0d want 72", d);
    end
    n_chk++;
    if (n !== 1) begin
      n_fail++;
      $display("FAIL lb_done_cnt got %0d want 1", n);
    end
    n_chk++;
    if (r !== 8) begin
      n_fail++;
      $display("FAIL lb_sclk_rises got %0d want 8", r);
    end
    n_chk++;
    if (mb !== 8'hA5) begin
      n_fail++;
      $display("FAIL lb_mosi_bits got %h want a5", mb);
    end
    n_chk++;
    if (cl !== 72) begin
      n_fail++;
      $display("FAIL lb_cs_low got %0d want 72", cl);
    end
    n_chk++;
    if (b1.rx_data !== 8'hA5 || b1.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_rx got %h busy %b want a5 0", b1.rx_data, b1.busy);
    end
  endtask

  task automatic test_tied_miso();
    int d, n, r, cl, mh;
    logic [7:0] mb;
    mode = 1;
    run_xfer(8'h00, -1, d, n, r, mb, cl, mh);
    n_chk++;
    if (b1.rx_data !== 8'hFF || d !== 72) begin
      n_fail++;
      $display("FAIL tied1_rx got %h at %0d want ff at 72", b1.rx_data, d);
    end
    n_chk++;
    if (mh !== 0) begin
      n_fail++;
      $display("FAIL tied1_mosi_hi got %0d want 0", mh);
    end
    mode = 2;
    run_xfer(8'hFF, -1, d, n, r, mb, cl, mh);
    n_chk++;
    if (b1.rx_data !== 8'h00 || mb !== 8'hFF) begin
      n_fail++;
      $display("FAIL tied0_rx got %h mosi %h want 00 ff", b1.rx_data, mb);
    end
    mode = 0;
  endtask

  task automatic test_start_while_busy();
    int d, n, r, cl, mh;
    logic [7:0] mb;
    mode = 0;
    run_xfer(8'h5A, 20, d, n, r, mb, cl, mh);
    n_chk++;
    if (n !== 1 || d !== 72) begin
      n_fail++;
      $display("FAIL busy_start got %0d dones at %0d want 1 at 72", n, d);
    end
    n_chk++;
    if (b1.rx_data !== 8'h5A || r !== 8) begin
      n_fail++;
      $display("FAIL busy_rx got %h rises %0d want 5a 8", b1.rx_data, r);
    end
  endtask

  task automatic test_back_to_back();
    int cs_hi;
    cs_hi = 0;
    mode = 0;
    b1.tx_data = 8'h81;
    b1.start   = 1'b1;
    tick1();
    for (int c = 1; c <= 150; c++) begin
      tick1();
      if (c <= 144 && b1.cs_n) cs_hi++;
      if (c == 72) begin
        n_chk++;
        if (b1.done !== 1'b1 || b1.rx_data !== 8'h81) begin
          n_fail++;
          $display("FAIL b2b_first got done %b rx %h want 1 81",
                   b1.done, b1.rx_data);
        end
        b1.tx_data = 8'h7E;
      end
      if (c == 73) begin
        n_chk++;
        if (b1.cs_n !== 1'b0 || b1.done !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_restart got cs_n %b done %b want 0 0",
                   b1.cs_n, b1.done);
        end
        b1.start = 1'b0;
      end
      if (c == 144) begin
        n_chk++;
        if (b1.done !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_early_done got %b want 0", b1.done);
        end
      end
      if (c == 145) begin
        n_chk++;
        if (b1.done !== 1'b1 || b1.rx_data !== 8'h7E) begin
          n_fail++;
          $display("FAIL b2b_second got done %b rx %h want 1 7e",
                   b1.done, b1.rx_data);
        end
      end
    end
    n_chk++;
    if (cs_hi !== 1) begin
      n_fail++;
      $display("FAIL b2b_cs_gap got %0d want 1", cs_hi);
    end
  endtask

  task automatic test_reset_abort();
    int d, n, r, cl, mh;
    int nd;
    logic [7:0] mb;
    nd = 0;
    mode = 0;
    b1.tx_data = 8'hC3;
    b1.start   = 1'b1;
    tick1();
    b1.start = 1'b0;
    repeat (30) tick1();
    #2;
    reset = 1'b1;
    #1;
    n_chk++;
    if ({b1.cs_n, b1.sclk, b1.busy} !== 3'b100 || b1.rx_data !== 8'h00) begin
      n_fail++;
      $display("FAIL abort_pins got cs_n/sclk/busy %b rx %h want 100 00",
               {b1.cs_n, b1.sclk, b1.busy}, b1.rx_data);
    end
    for (int c = 0; c < 3; c++) begin
      tick1();
      if (b1.done) nd++;
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick1();
      if (b1.done) nd++;
    end
    n_chk++;
    if (nd !== 0 || b1.cs_n !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_no_done got %0d dones cs_n %b want 0 1",
               nd, b1.cs_n);
    end
    run_xfer(8'h3C, -1, d, n, r, mb, cl, mh);
    n_chk++;
    if (d !== 72 || b1.rx_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL abort_recover got %h at %0d want 3c at 72",
               b1.rx_data, d);
    end
  endtask

  task automatic test_fast_wide();
    int d, r, hi;
    logic prev;
    d  = -1;
    r  = 0;
    hi = 0;
    b2.tx_data = 16'hBEEF;
    b2.start   = 1'b1;
    tick1();
    b2.start = 1'b0;
    prev = b2.sclk;
    for (int c = 1; c <= 45; c++) begin
      tick1();
      if (b2.sclk && !prev) r++;
      if (b2.sclk) hi++;
      prev = b2.sclk;
      if (b2.done && d < 0) d = c;
    end
    n_chk++;
    if (d !== 34) begin
      n_fail++;
      $display("FAIL fast_done_at got %0d want 34", d);
    end
    n_chk++;
    if (b2.rx_data !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL fast_rx got %h want beef", b2.rx_data);
    end
    n_chk++;
    if (r !== 16 || hi !== 16) begin
      n_fail++;
      $display("FAIL fast_sclk got rises %0d high %0d want 16 16", r, hi);
    end
  endtask

  initial begin
    b1.start   = 1'b0;
    b1.tx_data = '0;
    b2.start   = 1'b0;
    b2.tx_data = '0;
    test_reset();
    test_loopback();
    test_tied_miso();
    test_start_while_busy();
    test_back_to_back();
    test_reset_abort();
    test_fast_wide();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
